// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Request/response memory bus bundle (one per requester and memory).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        resp;

    // master issues commands and receives data/completion
    modport master (output read, write, address, wdata, wmask, input rdata, resp);
    modport slave  (input read, write, address, wdata, wmask, output rdata, resp);
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch (I) and
//            load/store (D) with bounded D priority to avoid fetch starvation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_D_BURST = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   i_port,
    mem_port_arbiter_if.slave   d_port,
    mem_port_arbiter_if.master  mem_port
);

    localparam logic [3:0] c_max_d_burst = 4'(MAX_D_BURST);
    localparam logic [3:0] c_streak_sat  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;
    logic [3:0]  r_d_streak;

    logic        w_d_req;
    logic        w_d_wins;
    logic        w_i_resp;
    logic        w_d_resp;
    logic        w_unused_i;

    assign w_d_req  = d_port.read | d_port.write;
    assign w_d_wins = w_d_req & ((r_d_streak < c_max_d_burst) | ~i_port.read);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_wmask   <= 4'h0;
            r_d_streak    <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_wins) begin
                        // Simultaneous read+write is a protocol error; the write wins.
                        r_state       <= ST_SERVE_D;
                        r_mem_write   <= d_port.write;
                        r_mem_read    <= d_port.read & ~d_port.write;
                        r_mem_address <= d_port.address;
                        r_mem_wdata   <= d_port.write ? d_port.wdata : 32'h0;
                        r_mem_wmask   <= d_port.write ? d_port.wmask : 4'h0;
                        if (i_port.read)
                            r_d_streak <= (r_d_streak == c_streak_sat) ? c_streak_sat
                                                                       : r_d_streak + 4'd1;
                        else
                            r_d_streak <= 4'h0;
                    end else if (i_port.read) begin
                        r_state       <= ST_SERVE_I;
                        r_mem_read    <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= i_port.address;
                        r_mem_wdata   <= 32'h0;
                        r_mem_wmask   <= 4'h0;
                        r_d_streak    <= 4'h0;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    // Command stays frozen until memory completes.
                    if (mem_port.resp) begin
                        r_state     <= ST_IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_port.read    = r_mem_read;
    assign mem_port.write   = r_mem_write;
    assign mem_port.address = r_mem_address;
    assign mem_port.wdata   = r_mem_wdata;
    assign mem_port.wmask   = r_mem_wmask;

    // Completion is steered combinationally to the granted requester only.
    assign w_i_resp = (r_state == ST_SERVE_I) & mem_port.resp;
    assign w_d_resp = (r_state == ST_SERVE_D) & mem_port.resp;

    assign i_port.resp  = w_i_resp;
    assign i_port.rdata = w_i_resp ? mem_port.rdata : 32'h0;
    assign d_port.resp  = w_d_resp;
    assign d_port.rdata = w_d_resp ? mem_port.rdata : 32'h0;

    // Fetch side never writes.
    assign w_unused_i = ^{i_port.write, i_port.wdata, i_port.wmask};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench: expected memory commands are queued as requests
//            are raised and checked as the arbiter issues them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if i_bus ();
    mem_port_arbiter_if d_bus ();
    mem_port_arbiter_if m_bus ();

    mem_port_arbiter #(.MAX_D_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_port   (i_bus),
        .d_port   (d_bus),
        .mem_port (m_bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) assert (!(d_bus.read && d_bus.write))
            else $error("protocol error: d_read and d_write both high");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, need 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.mask = mask;
        exp_q.push_back(c);
    endtask

    // Waits (bounded) for the next command on the memory port and checks it
    // against the scoreboard head; returns on the negedge it was first seen.
    task automatic await_grant(output cmd_t e, output bit ok);
        int n;
        bit seen;
        n = 0; seen = 1'b0; ok = 1'b0;
        e.wr = 1'b0; e.addr = 32'h0; e.wdata = 32'h0; e.mask = 4'h0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = m_bus.read | m_bus.write;
        end
        check_val("grant_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check_val("grant_lat", n, 32'd2);
        check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        ok = 1'b1;
        check_val("cmd_write", 32'(m_bus.write), 32'(e.wr));
        check_val("cmd_read",  32'(m_bus.read),  32'(!e.wr));
        check_val("cmd_addr",  m_bus.address, e.addr);
        check_val("cmd_wmask", 32'(m_bus.wmask), e.wr ? 32'(e.mask) : 32'd0);
        if (e.wr) check_val("cmd_wdata", m_bus.wdata, e.wdata);
    endtask

    // Serves one granted command with the given latency and checks routing.
    task automatic serve(input bit who_d, input int lat, input logic [31:0] rdata, input bit mutate);
        cmd_t e;
        bit   ok;
        await_grant(e, ok);
        if (!ok) return;
        if (mutate) begin
            d_bus.address = 32'h0000_0300;
            d_bus.wdata   = 32'h5555_AAAA;
        end
        repeat (lat - 1) begin
            @(negedge clk);
            check_val("hold_addr", m_bus.address, e.addr);
            check_val("hold_cmd", 32'({m_bus.read, m_bus.write}), e.wr ? 32'd1 : 32'd2);
        end
        m_bus.resp  = 1'b1;
        m_bus.rdata = rdata;
        #1;
        check_val(who_d ? "d_resp" : "i_resp", who_d ? 32'(d_bus.resp) : 32'(i_bus.resp), 32'd1);
        check_val(who_d ? "d_rdata" : "i_rdata", who_d ? d_bus.rdata : i_bus.rdata, rdata);
        check_val(who_d ? "i_resp_quiet" : "d_resp_quiet",
                  who_d ? 32'(i_bus.resp) : 32'(d_bus.resp), 32'd0);
        check_val(who_d ? "i_rdata_zero" : "d_rdata_zero",
                  who_d ? i_bus.rdata : d_bus.rdata, 32'd0);
        @(posedge clk);
        #1;
        m_bus.resp  = 1'b0;
        m_bus.rdata = 32'h0;
        check_val("cmd_clear", 32'({m_bus.read, m_bus.write}), 32'd0);
    endtask

    initial begin
        cmd_t e;
        bit   ok;
        rst = 1'b0;
        i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.address = 32'h0;
        i_bus.wdata = 32'h0; i_bus.wmask = 4'h0;
        d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.address = 32'h0;
        d_bus.wdata = 32'h0; d_bus.wmask = 4'h0;
        m_bus.resp = 1'b0; m_bus.rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_cmd",   32'({m_bus.read, m_bus.write}), 32'd0);
        check_val("rst_addr",  m_bus.address, 32'h0);
        check_val("rst_wdata", m_bus.wdata, 32'h0);
        check_val("rst_wmask", 32'(m_bus.wmask), 32'd0);
        check_val("rst_resp",  32'({i_bus.resp, d_bus.resp}), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Fetch alone
        i_bus.read = 1'b1; i_bus.address = 32'h0000_0060;
        push_exp(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        serve(1'b0, 3, 32'h0000_0013, 1'b0);
        i_bus.read = 1'b0;

        // Tie: D store wins, fetch follows after the idle bubble
        i_bus.read = 1'b1; i_bus.address = 32'h0000_0080;
        d_bus.write = 1'b1; d_bus.address = 32'h0000_0100;
        d_bus.wdata = 32'hDEAD_BEEF; d_bus.wmask = 4'b0011;
        push_exp(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
        push_exp(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        serve(1'b1, 2, 32'h0000_0000, 1'b0);
        d_bus.write = 1'b0; d_bus.wmask = 4'h0;
        serve(1'b0, 1, 32'h1234_5678, 1'b0);
        i_bus.read = 1'b0;

        // Command stability while the load address changes underneath
        d_bus.read = 1'b1; d_bus.address = 32'h0000_0200;
        push_exp(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        serve(1'b1, 4, 32'hCAFE_0001, 1'b1);
        d_bus.read = 1'b0; d_bus.address = 32'h0;

        // Starvation guard: four D grants then fetch is forced in
        i_bus.read = 1'b1; i_bus.address = 32'h0000_0400;
        d_bus.read = 1'b1; d_bus.address = 32'h0000_0500;
        for (int k = 0; k < 4; k++) push_exp(1'b0, 32'h0000_0500, 32'h0, 4'h0);
        push_exp(1'b0, 32'h0000_0400, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) serve(1'b1, 1, 32'hD000_0000 + 32'(k), 1'b0);
        serve(1'b0, 1, 32'h0000_400A, 1'b0);
        // Streak was cleared by the fetch grant, so D wins again despite pending fetch
        i_bus.address = 32'h0000_0404;
        push_exp(1'b0, 32'h0000_0500, 32'h0, 4'h0);
        push_exp(1'b0, 32'h0000_0404, 32'h0, 4'h0);
        serve(1'b1, 1, 32'hD000_0010, 1'b0);
        d_bus.read = 1'b0;
        serve(1'b0, 2, 32'h0000_404B, 1'b0);
        i_bus.read = 1'b0;

        // Spurious completion while idle
        @(negedge clk);
        m_bus.resp = 1'b1; m_bus.rdata = 32'hFFFF_FFFF;
        #1;
        check_val("spur_resp",  32'({i_bus.resp, d_bus.resp}), 32'd0);
        check_val("spur_irdat", i_bus.rdata, 32'h0);
        check_val("spur_drdat", d_bus.rdata, 32'h0);
        @(posedge clk); #1 m_bus.resp = 1'b0; m_bus.rdata = 32'h0;
        @(negedge clk);
        check_val("spur_idle", 32'({m_bus.read, m_bus.write}), 32'd0);
        @(posedge clk); #1;
        i_bus.read = 1'b1; i_bus.address = 32'h0000_0600;
        push_exp(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        serve(1'b0, 2, 32'h0000_0666, 1'b0);
        i_bus.read = 1'b0;

        // Reset mid-fetch, then a stale completion after release
        i_bus.read = 1'b1; i_bus.address = 32'h0000_0700;
        push_exp(1'b0, 32'h0000_0700, 32'h0, 4'h0);
        await_grant(e, ok);
        rst = 1'b0;
        #1;
        check_val("arst_read", 32'(m_bus.read), 32'd0);
        check_val("arst_addr", m_bus.address, 32'h0);
        i_bus.read = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        m_bus.resp = 1'b1; m_bus.rdata = 32'h0000_0077;
        #1;
        check_val("late_resp",  32'({i_bus.resp, d_bus.resp}), 32'd0);
        check_val("late_irdat", i_bus.rdata, 32'h0);
        @(posedge clk); #1 m_bus.resp = 1'b0; m_bus.rdata = 32'h0;
        @(negedge clk);
        check_val("late_idle", 32'({m_bus.read, m_bus.write}), 32'd0);

        check_val("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
